// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory-side bus responder with programmable latency and access counters
// Define MEM_BUS_CTRL_BURST_EN for 4-word line-fill reads; writes stay single-word.
module mem_bus_ctrl #(
  parameter int ADDR_BITS = 12,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 2
) (
  input  logic        CLK,
  input  logic        MRST_N,
  input  logic [31:0] Addr,
  input  logic        Read,
  input  logic        Write,
  inout  wire  [31:0] Bus,
  output logic        Valid,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  logic [31:0]          mem_q [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 is_wr_q, is_wr_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          rd_count_q, rd_count_d;
  logic [31:0]          wr_count_q, wr_count_d;
  logic                 mem_we;
  logic                 unused_addr;

`ifdef MEM_BUS_CTRL_BURST_EN
  logic [1:0]           beat_q, beat_d;
`endif

  assign unused_addr = ^{Addr[31:ADDR_BITS+2], Addr[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
`ifdef MEM_BUS_CTRL_BURST_EN
    beat_d     = beat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Write) begin
          is_wr_d = 1'b1;
          idx_d   = Addr[ADDR_BITS+1:2];
          wdata_d = Bus;
          cnt_d   = WR_LOAD;
          state_d = S_WAIT;
        end else if (Read) begin
          is_wr_d = 1'b0;
`ifdef MEM_BUS_CTRL_BURST_EN
          idx_d   = {Addr[ADDR_BITS+1:4], 2'b00};
`else
          idx_d   = Addr[ADDR_BITS+1:2];
`endif
          cnt_d   = RD_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_XFER;
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
`ifdef MEM_BUS_CTRL_BURST_EN
            idx_d   = idx_q + ADDR_BITS'(1);
            beat_d  = 2'd0;
`endif
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_XFER: begin
`ifdef MEM_BUS_CTRL_BURST_EN
        // Line fill: fetch the next word each beat until the fourth beat retires.
        if (!is_wr_q && beat_q != 2'd3) begin
          rdata_d = mem_q[idx_q];
          idx_d   = idx_q + ADDR_BITS'(1);
          beat_d  = beat_q + 2'd1;
        end else begin
          state_d = S_GAP;
          if (is_wr_q) wr_count_d = wr_count_q + 32'd1;
          else         rd_count_d = rd_count_q + 32'd1;
        end
`else
        state_d = S_GAP;
        if (is_wr_q) wr_count_d = wr_count_q + 32'd1;
        else         rd_count_d = rd_count_q + 32'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
`ifdef MEM_BUS_CTRL_BURST_EN
      beat_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
`ifdef MEM_BUS_CTRL_BURST_EN
      beat_q     <= beat_d;
`endif
    end
  end

  // The array holds its contents across reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign Valid    = (state_q == S_XFER);
  assign Bus      = (state_q == S_XFER && !is_wr_q) ? rdata_q : 32'bz;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl with a word-array reference model
module tb_mem_bus_ctrl;

  localparam int ADDR_BITS = 12;
  localparam int RD_LAT    = 4;
  localparam int WR_LAT    = 2;
  localparam int DEPTH     = 1 << ADDR_BITS;
`ifdef MEM_BUS_CTRL_BURST_EN
  localparam int BEATS = 4;
`else
  localparam int BEATS = 1;
`endif

  logic        CLK;
  logic        MRST_N;
  logic [31:0] Addr;
  logic        Read;
  logic        Write;
  wire  [31:0] Bus;
  logic        Valid;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  logic [31:0] bus_drv;
  logic        bus_oe;
  assign Bus = bus_oe ? bus_drv : 32'bz;

  mem_bus_ctrl #(.ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .CLK(CLK), .MRST_N(MRST_N), .Addr(Addr), .Read(Read), .Write(Write),
    .Bus(Bus), .Valid(Valid), .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    bit          rd;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m, wr_m;
  int          cyc;
  int          checks, errors;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Valid cycle must match the oldest outstanding beat.
  always @(negedge CLK) begin
    if (MRST_N && Valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(Valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_data) chk("read_data", Bus, e.data);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missing_valid_cycle", 32'(cyc), 32'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge where it is idle again.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold);
    int s, idx, base, lat;
    Read  = rd;
    Write = wr;
    Addr  = addr;
    if (wr) begin
      bus_oe  = 1'b1;
      bus_drv = data;
    end
    @(negedge CLK);
    s   = cyc;
    idx = int'((addr >> 2) % DEPTH);
    if (wr) begin
      mem_m[idx] = data;
      wr_m++;
      exp_q.push_back('{rd: 1'b0, chk_data: 1'b0, data: 32'd0, cyc: s + WR_LAT});
      lat = WR_LAT + 1;
    end else begin
      rd_m++;
      base = (idx / BEATS) * BEATS;
      for (int k = 0; k < BEATS; k++)
        exp_q.push_back('{rd: 1'b1, chk_data: 1'b1, data: mem_m[base + k], cyc: s + RD_LAT + k});
      lat = RD_LAT + BEATS;
    end
    bus_oe = 1'b0;
    bus_drv = $urandom;
    if (!hold) begin
      Read  = 1'b0;
      Write = 1'b0;
      Addr  = $urandom;
    end
    repeat (lat + 1) @(negedge CLK);
    chk("rd_count", rd_count, rd_m);
    chk("wr_count", wr_count, wr_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int idx;
    checks = 0; errors = 0; rd_m = 0; wr_m = 0;
    MRST_N = 1'b0; Read = 1'b0; Write = 1'b0; Addr = 32'd0;
    bus_oe = 1'b0; bus_drv = 32'd0;
    repeat (3) @(negedge CLK);
    chk("reset_valid", 32'(Valid), 32'd0);
    chk("reset_rd_count", rd_count, 32'd0);
    chk("reset_wr_count", wr_count, 32'd0);
    MRST_N = 1'b1;
    @(negedge CLK);

    // Reset asserted mid-WAIT.
    Read = 1'b1; Addr = 32'h0;
    @(negedge CLK);
    Read = 1'b0;
    @(negedge CLK);
    #1 MRST_N = 1'b0;
    #1 chk("reset_mid_wait_valid", 32'(Valid), 32'd0);
    @(negedge CLK);
    MRST_N = 1'b1;
    @(negedge CLK);

    // Reset asserted during the first XFER beat drops Valid at once.
    Read = 1'b1; Addr = 32'h0;
    @(negedge CLK);
    exp_q.push_back('{rd: 1'b1, chk_data: 1'b0, data: 32'd0, cyc: cyc + RD_LAT});
    Read = 1'b0;
    repeat (RD_LAT) @(negedge CLK);
    #1 MRST_N = 1'b0;
    #1 chk("reset_mid_xfer_valid", 32'(Valid), 32'd0);
    chk("reset_mid_xfer_rd_count", rd_count, 32'd0);
    @(negedge CLK);
    MRST_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("idle_rd_count", rd_count, 32'd0);
    chk("idle_valid", 32'(Valid), 32'd0);

    // Fill words 0..63 so every later read, single or burst, hits known data.
    for (int i = 0; i < 64; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Held read: back-to-back samples while Read stays high.
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h4 + 32'(1 << (ADDR_BITS + 2)), 32'h0, 1'b0);

    do_req(1'b0, 1'b1, 32'h40, 32'hA5A50040, 1'b0);
    do_req(1'b0, 1'b1, 32'h80, 32'h5A5A0080, 1'b0);
    Read = 1'b1; Addr = 32'h40;
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    Read = 1'b0;

`ifdef MEM_BUS_CTRL_BURST_EN
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'(i + 1), 1'b0);
    do_req(1'b1, 1'b0, 32'h108, 32'h0, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      idx = int'($urandom_range(0, 63));
      a = ($urandom & ~32'h3FFF) | 32'(idx << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 2) == 0) do_req(1'($urandom), 1'b1, a, $urandom, 1'b0);
      else                            do_req(1'b1, 1'b0, a, 32'h0, 1'b0);
    end

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
